// File: rtl/regfile_pkg.sv
// Shared types and constants for the register-file write path.
// Both writeback sources and the write stage agree on these layouts.
package regfile_pkg;

    localparam int DATA_W   = 64;
    localparam int ADDR_W   = 5;
    localparam int NUM_REGS = 32;
    localparam int CNT_W    = 8;
    localparam logic [ADDR_W-1:0] ZERO_REG = 5'd31;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wr_req_t;

    typedef struct packed {
        logic    valid;
        wr_req_t req;
    } stage_t;

    typedef enum logic {
        REQ_ALU  = 1'b0,
        REQ_LOAD = 1'b1
    } req_id_e;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] value);
        return (value == {CNT_W{1'b1}}) ? value : value + 1'b1;
    endfunction

endpackage

// File: rtl/regfile_write_arbiter_decoder.sv
// One-hot decoder with enable driving the per-register write enables.
// The output is all-zero whenever the enable is low.
module decoder_5to32
    import regfile_pkg::*;
(
    input  logic [ADDR_W-1:0]   addr_i,
    input  logic                en_i,
    output logic [NUM_REGS-1:0] dec_o
);

    always_comb begin
        dec_o = '0;
        if (en_i) begin
            dec_o[addr_i] = 1'b1;
        end
    end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter between ALU and load writeback feeding one registered
// write stage in front of the 32 x 64-bit register file write port.
module regfile_write_arbiter
    import regfile_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic                req0_valid,
    input  logic [ADDR_W-1:0]   req0_addr,
    input  logic [DATA_W-1:0]   req0_data,
    output logic                req0_ready,
    input  logic                req1_valid,
    input  logic [ADDR_W-1:0]   req1_addr,
    input  logic [DATA_W-1:0]   req1_data,
    output logic                req1_ready,
    input  logic                rf_stall,
    output logic [NUM_REGS-1:0] reg_en,
    output logic [DATA_W-1:0]   wr_data,
    output logic                wr_busy,
    output logic [ADDR_W-1:0]   wr_pend_addr,
    output logic                last_grant,
    output logic [CNT_W-1:0]    drop_cnt
);

    stage_t           stage_q, stage_d;
    req_id_e          lastGrant_q, lastGrant_d;
    logic [CNT_W-1:0] dropCnt_q, dropCnt_d;

    logic    grantValid;
    req_id_e grantSel;
    logic    accept;
    wr_req_t winReq;
    logic    isDrop;

    // With both requesters valid, the one that did not win last time goes next.
    always_comb begin
        grantValid = req0_valid || req1_valid;
        grantSel   = REQ_ALU;
        if (req0_valid && req1_valid) begin
            grantSel = (lastGrant_q == REQ_ALU) ? REQ_LOAD : REQ_ALU;
        end else if (req1_valid) begin
            grantSel = REQ_LOAD;
        end
    end

    assign accept     = grantValid && !rf_stall;
    assign req0_ready = accept && (grantSel == REQ_ALU);
    assign req1_ready = accept && (grantSel == REQ_LOAD);

    always_comb begin
        winReq.addr = req0_addr;
        winReq.data = req0_data;
        if (grantSel == REQ_LOAD) begin
            winReq.addr = req1_addr;
            winReq.data = req1_data;
        end
    end

    assign isDrop = (winReq.addr == ZERO_REG);

    // A stall freezes everything; otherwise the stage retires and may reload
    // in the same cycle. Data is left in place on retire to keep wr_data quiet.
    always_comb begin
        stage_d     = stage_q;
        lastGrant_d = lastGrant_q;
        dropCnt_d   = dropCnt_q;
        if (!rf_stall) begin
            stage_d.valid = 1'b0;
            if (accept) begin
                lastGrant_d = grantSel;
                if (isDrop) begin
                    dropCnt_d = sat_inc(dropCnt_q);
                end else begin
                    stage_d.valid = 1'b1;
                    stage_d.req   = winReq;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stage_q     <= '0;
            lastGrant_q <= REQ_LOAD;
            dropCnt_q   <= '0;
        end else begin
            stage_q     <= stage_d;
            lastGrant_q <= lastGrant_d;
            dropCnt_q   <= dropCnt_d;
        end
    end

    decoder_5to32 u_decoder (
        .addr_i (stage_q.req.addr),
        .en_i   (stage_q.valid && !rf_stall),
        .dec_o  (reg_en)
    );

    assign wr_data      = stage_q.req.data;
    assign wr_busy      = stage_q.valid;
    assign wr_pend_addr = stage_q.valid ? stage_q.req.addr : '0;
    assign last_grant   = lastGrant_q;
    assign drop_cnt     = dropCnt_q;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Scoreboard bench for regfile_write_arbiter: requester queues feed the DUT,
// accepted writes go to a scoreboard checked against reg_en/wr_data each cycle.
module tb_regfile_write_arbiter;
    import regfile_pkg::*;

    logic                clk = 1'b0;
    logic                reset;
    logic                req0_valid, req1_valid;
    logic [ADDR_W-1:0]   req0_addr, req1_addr;
    logic [DATA_W-1:0]   req0_data, req1_data;
    logic                req0_ready, req1_ready;
    logic                rf_stall;
    logic [NUM_REGS-1:0] reg_en;
    logic [DATA_W-1:0]   wr_data;
    logic                wr_busy;
    logic [ADDR_W-1:0]   wr_pend_addr;
    logic                last_grant;
    logic [CNT_W-1:0]    drop_cnt;

    int checkCount = 0;
    int failCount  = 0;

    wr_req_t rq0[$];
    wr_req_t rq1[$];
    wr_req_t sb[$];

    logic stallReq   = 1'b0;
    logic modelLast  = 1'b1;
    int   modelDrop  = 0;
    logic accept0    = 1'b0;
    logic accept1    = 1'b0;
    logic monitorOn  = 1'b1;

    always #5 clk = ~clk;

    regfile_write_arbiter dut (
        .clk          (clk),
        .reset        (reset),
        .req0_valid   (req0_valid),
        .req0_addr    (req0_addr),
        .req0_data    (req0_data),
        .req0_ready   (req0_ready),
        .req1_valid   (req1_valid),
        .req1_addr    (req1_addr),
        .req1_data    (req1_data),
        .req1_ready   (req1_ready),
        .rf_stall     (rf_stall),
        .reg_en       (reg_en),
        .wr_data      (wr_data),
        .wr_busy      (wr_busy),
        .wr_pend_addr (wr_pend_addr),
        .last_grant   (last_grant),
        .drop_cnt     (drop_cnt)
    );

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checkCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    function automatic wr_req_t mkReq(input int addr, input logic [DATA_W-1:0] data);
        wr_req_t r;
        r.addr = ADDR_W'(addr);
        r.data = data;
        return r;
    endfunction

    task automatic driveInputs();
        req0_valid = (rq0.size() != 0);
        req1_valid = (rq1.size() != 0);
        if (req0_valid) begin
            req0_addr = rq0[0].addr;
            req0_data = rq0[0].data;
        end
        if (req1_valid) begin
            req1_addr = rq1[0].addr;
            req1_data = rq1[0].data;
        end
        rf_stall = stallReq;
    endtask

    // Round-robin rule: a lone requester wins; with two, the one not served last wins.
    task automatic decide();
        logic g0, g1;
        g0 = req0_valid && (!req1_valid || modelLast == 1'b1);
        g1 = req1_valid && (!req0_valid || modelLast == 1'b0);
        accept0 = g0 && !rf_stall;
        accept1 = g1 && !rf_stall;
        checkOutput("req0_ready", req0_ready, accept0);
        checkOutput("req1_ready", req1_ready, accept1);
        checkOutput("last_grant", last_grant, modelLast);
        checkOutput("drop_cnt", drop_cnt, modelDrop);
    endtask

    task automatic commit();
        wr_req_t w;
        w = '0;
        if (accept0) begin
            w = rq0.pop_front();
            modelLast = 1'b0;
        end else if (accept1) begin
            w = rq1.pop_front();
            modelLast = 1'b1;
        end
        if (accept0 || accept1) begin
            if (w.addr == ZERO_REG) modelDrop = (modelDrop >= 255) ? 255 : modelDrop + 1;
            else sb.push_back(w);
        end
        accept0 = 1'b0;
        accept1 = 1'b0;
    endtask

    task automatic applyStimulus(input int n);
        repeat (n) begin
            driveInputs();
            @(negedge clk);
            decide();
            @(posedge clk);
            commit();
            #1;
        end
    endtask

    // The scoreboard head is the write the stage should be holding right now.
    always @(negedge clk) begin
        logic [NUM_REGS-1:0] expEn;
        wr_req_t             head;
        if (monitorOn) begin
            if (sb.size() > 1) checkOutput("sb_depth", sb.size(), 1);
            if (sb.size() == 0) begin
                checkOutput("wr_busy_idle", wr_busy, 0);
                checkOutput("wr_pend_idle", wr_pend_addr, 0);
                checkOutput("reg_en_idle", reg_en, 0);
            end else begin
                head = sb[0];
                checkOutput("wr_busy", wr_busy, 1);
                checkOutput("wr_pend_addr", wr_pend_addr, head.addr);
                if (rf_stall) begin
                    checkOutput("reg_en_stalled", reg_en, 0);
                end else begin
                    expEn = 32'd1 << head.addr;
                    checkOutput("reg_en", reg_en, expEn);
                    checkOutput("wr_data", wr_data, head.data);
                    void'(sb.pop_front());
                end
            end
        end
    end

    initial begin
        int guard;
        reset      = 1'b1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        req0_addr  = '0;
        req1_addr  = '0;
        req0_data  = '0;
        req1_data  = '0;
        rf_stall   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_reg_en", reg_en, 0);
        checkOutput("rst_wr_data", wr_data, 0);
        checkOutput("rst_wr_busy", wr_busy, 0);
        checkOutput("rst_pend", wr_pend_addr, 0);
        checkOutput("rst_last_grant", last_grant, 1);
        checkOutput("rst_drop_cnt", drop_cnt, 0);
        reset = 1'b0;

        rq0.push_back(mkReq(3, 64'hDEADBEEF));
        applyStimulus(3);

        for (int i = 0; i < 2; i++) begin
            rq0.push_back(mkReq(1, {$urandom, $urandom}));
            rq1.push_back(mkReq(2, {$urandom, $urandom}));
        end
        applyStimulus(6);

        for (int i = 0; i < 3; i++) rq1.push_back(mkReq(31, {$urandom, $urandom}));
        applyStimulus(4);
        checkOutput("drop_cnt_three", drop_cnt, 3);
        for (int i = 0; i < 260; i++) rq1.push_back(mkReq(31, {$urandom, $urandom}));
        applyStimulus(262);
        checkOutput("drop_cnt_saturated", drop_cnt, 255);

        rq0.push_back(mkReq(7, 64'h0123_4567_89AB_CDEF));
        applyStimulus(1);
        stallReq = 1'b1;
        rq1.push_back(mkReq(4, 64'h44));
        applyStimulus(3);
        stallReq = 1'b0;
        applyStimulus(3);

        rq0.push_back(mkReq(5, 64'h5555));
        applyStimulus(1);
        driveInputs();
        checkOutput("pre_reset_busy", wr_busy, 1);
        checkOutput("pre_reset_reg_en", reg_en, 32'h20);
        #1 reset = 1'b1;
        #1;
        checkOutput("async_reset_reg_en", reg_en, 0);
        checkOutput("async_reset_busy", wr_busy, 0);
        checkOutput("async_reset_last_grant", last_grant, 1);
        sb.delete();
        modelLast = 1'b1;
        modelDrop = 0;
        @(negedge clk);
        #1 reset = 1'b0;
        @(posedge clk);
        #1;

        rq0.push_back(mkReq(9, 64'h1));
        rq1.push_back(mkReq(9, 64'h2));
        applyStimulus(4);

        repeat (400) begin
            if ($urandom_range(0, 2) == 0 && rq0.size() < 3)
                rq0.push_back(mkReq($urandom_range(0, 31), {$urandom, $urandom}));
            if ($urandom_range(0, 2) == 0 && rq1.size() < 3)
                rq1.push_back(mkReq($urandom_range(0, 31), {$urandom, $urandom}));
            stallReq = ($urandom_range(0, 4) == 0);
            applyStimulus(1);
        end

        stallReq = 1'b0;
        guard = 0;
        while ((rq0.size() != 0 || rq1.size() != 0) && guard < 50) begin
            applyStimulus(1);
            guard++;
        end
        checkOutput("drain_pending", rq0.size() + rq1.size(), 0);
        applyStimulus(2);
        checkOutput("sb_empty", sb.size(), 0);

        monitorOn = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
        $finish;
    end

endmodule
